// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak sponge sequencer.
// Holds the FSM state encoding, the lane count and lane-counter width, and the
// default RUN-state timeout for the optional watchdog.
package keccak_pkg;

  localparam int unsigned LANES       = 25;
  localparam int unsigned LANE_CNT_W  = 5;
  localparam int unsigned DEF_TIMEOUT = 31;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_RUN    = 4'b0100,
    ST_UNLOAD = 4'b1000
  } seq_state_e;

endpackage

// File: rtl/keccak_seq_watchdog.sv
// RUN-state watchdog for the Keccak sponge sequencer.
// A down-counter is loaded with TIMEOUT-1 as the sequencer enters RUN. It then
// counts down one step per RUN cycle. expired is high during the TIMEOUT-th RUN
// cycle, which is the cycle in which the counter has reached zero.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   load     in   reload the counter (the cycle before the first RUN cycle)
//   en       in   sequencer is in RUN
//   expired  out  terminal count reached while enabled
module keccak_seq_watchdog
  import keccak_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/keccak_sponge_sequencer.sv
// Host-side sequencer for the masked Keccak core.
// It performs these steps in order:
//   1. Loads 25 shared lanes from a valid/ready stream.
//   2. Releases the core by deasserting CoreReset.
//   3. Waits for CoreReady.
//   4. Streams the permuted lanes back out.
// This block is the only driver of the core's reset.
//
// Optional feature: define KECCAK_SEQ_WATCHDOG_EN to add a RUN-state timeout.
// When the timeout fires, the sequencer sets the sticky Error flag, returns to
// IDLE and puts the core back into reset.
//
// state  | meaning
// IDLE   | core held in reset, waiting for lane 0
// LOAD   | core held in reset, writing lanes 1..LANES-1
// RUN    | core released, waiting for CoreReady
// UNLOAD | core holds its result, lanes streamed out
//
// Ports:
//   Clock, Reset                       clock, async active-high reset
//   InValid/InReady/InData             input lane stream (share 0 in LSBs)
//   OutValid/OutReady/OutData/OutLast  output lane stream
//   Busy, Error                        status
//   CoreReset, CoreReady               core control
//   CoreLaneWe/Idx/WData/RData         core lane access
module keccak_sponge_sequencer #(
  parameter int unsigned W       = 8,
  parameter int unsigned SHARES  = 2,
  parameter int unsigned LANES   = keccak_pkg::LANES,
  parameter int unsigned TIMEOUT = keccak_pkg::DEF_TIMEOUT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [W*SHARES-1:0] InData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [W*SHARES-1:0] OutData,
  output logic                OutLast,
  output logic                Busy,
  output logic                Error,
  output logic                CoreReset,
  input  logic                CoreReady,
  output logic                CoreLaneWe,
  output logic [4:0]          CoreLaneIdx,
  output logic [W*SHARES-1:0] CoreLaneWData,
  input  logic [W*SHARES-1:0] CoreLaneRData
);

  import keccak_pkg::*;

  seq_state_e            state_q, state_d;
  logic [LANE_CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  logic                  core_reset_q, core_reset_d;
  logic                  in_accept, out_accept, last_lane, wd_expired;

  assign last_lane  = (lane_cnt_q == LANE_CNT_W'(LANES - 1));
  assign InReady    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign in_accept  = InValid && InReady;
  assign out_accept = (state_q == ST_UNLOAD) && OutReady;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_accept) begin
          lane_cnt_d = LANE_CNT_W'(1);
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_accept) begin
          if (last_lane) begin
            lane_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (CoreReady) begin
          state_d = ST_UNLOAD;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_UNLOAD: begin
        if (out_accept) begin
          if (last_lane) begin
            lane_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lane_cnt_d = '0;
      end
    endcase
    // CoreReset is derived from next state so the core is released
    // on the very first RUN cycle and re-held on the first IDLE cycle.
    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      lane_cnt_q   <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

`ifdef KECCAK_SEQ_WATCHDOG_EN
  logic error_q, error_d;
  logic wd_load;

  assign wd_load = (state_q != ST_RUN) && (state_d == ST_RUN);

  keccak_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (Clock),
    .rst     (Reset),
    .load    (wd_load),
    .en      (state_q == ST_RUN),
    .expired (wd_expired)
  );

  always_comb begin
    error_d = error_q;
    if (in_accept) begin
      error_d = 1'b0;
    end else if ((state_q == ST_RUN) && !CoreReady && wd_expired) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign Error = error_q;
`else
  assign wd_expired = 1'b0;
  assign Error      = 1'b0;
`endif

  assign CoreReset     = core_reset_q;
  assign CoreLaneWe    = in_accept;
  assign CoreLaneIdx   = lane_cnt_q;
  assign CoreLaneWData = InData;
  assign OutValid      = (state_q == ST_UNLOAD);
  assign OutData       = CoreLaneRData;
  assign OutLast       = (state_q == ST_UNLOAD) && last_lane;
  assign Busy          = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_UNLOAD);

endmodule

// File: tb/tb_keccak_sponge_sequencer.sv
module tb_keccak_sponge_sequencer;

  localparam int DW = 16;
  localparam logic [DW-1:0] PERM_KEY = 16'hC35A;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] InData = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [DW-1:0] OutData;
  logic          OutLast;
  logic          Busy;
  logic          Error;
  logic          CoreReset;
  logic          CoreReady;
  logic          CoreLaneWe;
  logic [4:0]    CoreLaneIdx;
  logic [DW-1:0] CoreLaneWData;
  logic [DW-1:0] CoreLaneRData;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  keccak_sponge_sequencer #(.W(8), .SHARES(2), .LANES(25), .TIMEOUT(31)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
    .Busy(Busy), .Error(Error),
    .CoreReset(CoreReset), .CoreReady(CoreReady),
    .CoreLaneWe(CoreLaneWe), .CoreLaneIdx(CoreLaneIdx),
    .CoreLaneWData(CoreLaneWData), .CoreLaneRData(CoreLaneRData)
  );

  // Core model: lane store; "permutation" XORs each lane with PERM_KEY once
  // ready_delay cycles have elapsed since CoreReset was released.
  logic [DW-1:0] core_mem [32];
  int core_run_cnt = 0;
  int ready_delay = 19;

  always @(posedge Clock) begin
    if (CoreLaneWe) core_mem[CoreLaneIdx] <= CoreLaneWData;
    if (CoreReset) core_run_cnt <= 0;
    else core_run_cnt <= core_run_cnt + 1;
  end

  assign CoreReady = !CoreReset && (core_run_cnt >= ready_delay);
  assign CoreLaneRData = CoreReady ? (core_mem[CoreLaneIdx] ^ PERM_KEY) : core_mem[CoreLaneIdx];

  logic [DW-1:0] in_lanes [25];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    #1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < 25; i++) in_lanes[i] = DW'($urandom);
  endtask

  task automatic load_lanes(input int gap_after, input int gap_len);
    for (int i = 0; i < 25; i++) begin
      if (i == gap_after + 1) begin
        InValid = 1'b0;
        InData = DW'($urandom);
        for (int g = 0; g < gap_len; g++) begin
          #1;
          vectors++;
          if (CoreLaneWe !== 1'b0 || CoreLaneIdx !== 5'(i) || InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL load_gap lane %0d gap %0d: We=%b Idx=%0d InReady=%b, want 0 %0d 1",
                     i, g, CoreLaneWe, CoreLaneIdx, InReady, i);
          end
          tick();
        end
      end
      InValid = 1'b1;
      InData = in_lanes[i];
      OutReady = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (CoreLaneWe !== 1'b1 || CoreLaneIdx !== 5'(i) || CoreLaneWData !== in_lanes[i] ||
          InReady !== 1'b1 || CoreReset !== 1'b1 || Busy !== (i != 0) || OutValid !== 1'b0) begin
        miscompares++;
        $display("FAIL load_beat %0d: We=%b Idx=%0d WData=%h InReady=%b CoreReset=%b Busy=%b OutValid=%b, want 1 %0d %h 1 1 %b 0",
                 i, CoreLaneWe, CoreLaneIdx, CoreLaneWData, InReady, CoreReset, Busy, OutValid,
                 i, in_lanes[i], (i != 0));
      end
      tick();
    end
    InValid = 1'b0;
    OutReady = 1'b0;
  endtask

  // Returns the number of edges from CoreReset release to first OutValid.
  task automatic wait_for_output(input int budget, output int cycles);
    cycles = 0;
    InValid = 1'($urandom_range(0, 1));
    #1;
    while (!OutValid && cycles < budget) begin
      vectors++;
      if (CoreLaneWe !== 1'b0 || CoreReset !== 1'b0 || Busy !== 1'b1 || InReady !== 1'b0) begin
        miscompares++;
        $display("FAIL run_state cycle %0d: We=%b CoreReset=%b Busy=%b InReady=%b, want 0 0 1 0",
                 cycles, CoreLaneWe, CoreReset, Busy, InReady);
      end
      tick();
      cycles++;
      InValid = 1'($urandom_range(0, 1));
      #1;
    end
    InValid = 1'b0;
    vectors++;
    if (OutValid !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_out timeout: OutValid=%b after %0d cycles, want 1", OutValid, cycles);
    end
  endtask

  // mode 0: always ready, 1: pattern 1-0-0-1, 2: random. abort_at>=0 asserts Reset at that beat.
  task automatic unload(input int mode, input int abort_at);
    int k;
    int cyc;
    logic [DW-1:0] exp_data;
    k = 0;
    cyc = 0;
    while (k < 25 && cyc < 400) begin
      case (mode)
        0: OutReady = 1'b1;
        1: OutReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
      InValid = 1'($urandom_range(0, 1));
      InData = DW'($urandom);
      #1;
      if (k == abort_at) begin
        Reset = 1'b1;
        #1;
        vectors++;
        if (OutValid !== 1'b0 || CoreReset !== 1'b1 || Busy !== 1'b0 || InReady !== 1'b1) begin
          miscompares++;
          $display("FAIL async_abort beat %0d: OutValid=%b CoreReset=%b Busy=%b InReady=%b, want 0 1 0 1",
                   k, OutValid, CoreReset, Busy, InReady);
        end
        tick();
        Reset = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b0;
        return;
      end
      exp_data = in_lanes[k] ^ PERM_KEY;
      vectors++;
      if (OutValid !== 1'b1 || OutData !== exp_data || OutLast !== (k == 24) ||
          CoreLaneIdx !== 5'(k) || CoreLaneWe !== 1'b0) begin
        miscompares++;
        $display("FAIL out_beat %0d: OutValid=%b OutData=%h OutLast=%b Idx=%0d We=%b, want 1 %h %b %0d 0",
                 k, OutValid, OutData, OutLast, CoreLaneIdx, CoreLaneWe, exp_data, (k == 24), k);
      end
      if (OutReady) k++;
      tick();
      cyc++;
    end
    OutReady = 1'b0;
    InValid = 1'b0;
    #1;
    vectors++;
    if (k != 25 || Busy !== 1'b0 || InReady !== 1'b1 || CoreReset !== 1'b1 || OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL unload_done: beats=%0d Busy=%b InReady=%b CoreReset=%b OutValid=%b, want 25 0 1 1 0",
               k, Busy, InReady, CoreReset, OutValid);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if (InReady !== 1'b1 || CoreReset !== 1'b1 || Busy !== 1'b0 || OutValid !== 1'b0 || Error !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: InReady=%b CoreReset=%b Busy=%b OutValid=%b Error=%b, want 1 1 0 0 0",
                 c, InReady, CoreReset, Busy, OutValid, Error);
      end
      tick();
    end
  endtask

  task automatic test_full_pass();
    int cycles;
    for (int i = 0; i < 25; i++) in_lanes[i] = DW'(i);
    ready_delay = 19;
    load_lanes(-1, 0);
    wait_for_output(200, cycles);
    vectors++;
    if (cycles != 20) begin
      miscompares++;
      $display("FAIL full_pass_latency: first OutValid %0d cycles after release, want 20", cycles);
    end
    unload(0, -1);
  endtask

  task automatic test_backpressure();
    int cycles;
    randomize_lanes();
    ready_delay = $urandom_range(0, 25);
    load_lanes(-1, 0);
    wait_for_output(200, cycles);
    vectors++;
    if (cycles != ready_delay + 1) begin
      miscompares++;
      $display("FAIL bp_latency: %0d cycles, want %0d", cycles, ready_delay + 1);
    end
    unload(1, -1);
  endtask

  task automatic test_input_gaps();
    int cycles;
    randomize_lanes();
    ready_delay = $urandom_range(0, 25);
    load_lanes(7, 3);
    wait_for_output(200, cycles);
    unload(0, -1);
  endtask

  task automatic test_async_reset();
    int cycles;
    randomize_lanes();
    ready_delay = $urandom_range(0, 25);
    load_lanes(-1, 0);
    wait_for_output(200, cycles);
    unload(0, 12);
    randomize_lanes();
    load_lanes(-1, 0);
    wait_for_output(200, cycles);
    unload(2, -1);
  endtask

  task automatic test_back_to_back();
    int cycles;
    for (int p = 0; p < 2; p++) begin
      randomize_lanes();
      ready_delay = $urandom_range(0, 25);
      load_lanes($urandom_range(0, 23), $urandom_range(0, 2));
      wait_for_output(200, cycles);
      vectors++;
      if (cycles != ready_delay + 1) begin
        miscompares++;
        $display("FAIL b2b_latency pass %0d: %0d cycles, want %0d", p, cycles, ready_delay + 1);
      end
      unload(2, -1);
    end
  endtask

  task automatic test_watchdog();
    randomize_lanes();
    ready_delay = 1000000;
    load_lanes(-1, 0);
`ifdef KECCAK_SEQ_WATCHDOG_EN
    for (int c = 0; c < 31; c++) begin
      InValid = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (Error !== 1'b0 || CoreReset !== 1'b0 || Busy !== 1'b1 || InReady !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_run cycle %0d: Error=%b CoreReset=%b Busy=%b InReady=%b, want 0 0 1 0",
                 c, Error, CoreReset, Busy, InReady);
      end
      tick();
    end
    InValid = 1'b0;
    #1;
    vectors++;
    if (Error !== 1'b1 || Busy !== 1'b0 || CoreReset !== 1'b1 || InReady !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_expire: Error=%b Busy=%b CoreReset=%b InReady=%b, want 1 0 1 1",
               Error, Busy, CoreReset, InReady);
    end
    InValid = 1'b1;
    InData = DW'($urandom);
    tick();
    InValid = 1'b0;
    #1;
    vectors++;
    if (Error !== 1'b0 || CoreLaneIdx !== 5'd1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_clear: Error=%b Idx=%0d Busy=%b, want 0 1 1", Error, CoreLaneIdx, Busy);
    end
`else
    for (int c = 0; c < 100; c++) begin
      InValid = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (Error !== 1'b0 || CoreReset !== 1'b0 || Busy !== 1'b1 || OutValid !== 1'b0) begin
        miscompares++;
        $display("FAIL no_wd_run cycle %0d: Error=%b CoreReset=%b Busy=%b OutValid=%b, want 0 0 1 0",
                 c, Error, CoreReset, Busy, OutValid);
      end
      tick();
    end
    InValid = 1'b0;
`endif
    pulse_reset();
    ready_delay = 19;
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_input_gaps();
    test_async_reset();
    test_back_to_back();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
